led_indicator_bank: RTL
=======================

Name: led_indicator_bank

Overview:
- Parametrised successor to the board bring-up LED blinker.
- Drives CHANNELS LEDs from one clock.
- Each channel is independently set to one of four modes: off, on, fixed-rate blink, or a repeating blink code (K flashes then a gap).
- Used for board status and error-code indication. A single shared prescaler sets the timebase for all channels.

Parameters:
CHANNELS, 2, number of LED channels (>=1)
TICK_DIV, 120000, clock cycles per timebase tick (10 ms at 12 MHz; >=2)
BLINK_TICKS, 50, ticks per half-period in BLINK mode (>=1)
ON_TICKS, 20, ticks LED is lit per flash in CODE mode (>=1)
OFF_TICKS, 30, ticks LED is dark between flashes in CODE mode (>=1)
GAP_TICKS, 150, extra dark ticks after the last flash of a code (>=1)

Ports:
clock  input  1  the single clock; all state on its rising edge
reset  input  1  asynchronous, active-high reset
mode  input  2*CHANNELS  per-channel mode, channel i at [2i+1:2i]: 00 OFF, 01 ON, 10 BLINK, 11 CODE
code  input  4*CHANNELS  per-channel flash count K for CODE mode, channel i at [4i+3:4i], 0..15
led  output  CHANNELS  registered LED drive, 1 = lit
cycle_pulse  output  CHANNELS  one-cycle strobe when a CODE sequence restarts after its gap

Behaviour:
- Reset (async assert, sync-to-clock deassert is the top level's job):
  - prescaler=0
  - all channels in restart state with stored cfg = {mode 00, code 0}
  - led=0, cycle_pulse=0
- Prescaler:
  - counts 0..TICK_DIV-1, then wraps to 0.
  - tick=1 for exactly the cycle where count==TICK_DIV-1.
  - Free-running; never reset by mode changes.
- Config capture: every edge, each channel compares {mode,code} inputs with its stored cfg. On mismatch:
  - store the new cfg;
  - restart the channel at that edge, per the entry rules below;
  - ignore any tick in that cycle for that channel.
  - led reflects the new mode after that edge (1-cycle latency).
- Per-channel timer: counts ticks within the current phase. Width is clog2 of the max of all *_TICKS parameters, +1. It is cleared on restart and on every phase change.
- OFF: led=0. ON: led=1. Timer and FSM idle.
- BLINK:
  - Entry: led=1, timer=0.
  - On a tick with timer==BLINK_TICKS-1: toggle led, timer=0. Otherwise increment on tick.
- CODE with K>=1 uses FSM states FLASH_ON, FLASH_OFF, GAP and a flash counter (4 bits).
  - Entry: FLASH_ON, led=1, flash=0, timer=0. No cycle_pulse on entry.
  - FLASH_ON: after ON_TICKS ticks -> FLASH_OFF, led=0.
  - FLASH_OFF: after OFF_TICKS ticks, if flash==K-1 -> GAP; else flash+1, -> FLASH_ON, led=1.
  - GAP: led=0. After GAP_TICKS ticks -> FLASH_ON, flash=0, led=1, and cycle_pulse=1 for that one cycle.
  - Sequence period = K*(ON_TICKS+OFF_TICKS)+GAP_TICKS ticks.
- CODE with K=0: led=0, FSM held at entry state, no cycle_pulse.
- Phase durations:
  - Tick-quantised: a phase of N ticks ends on its Nth tick.
  - The first phase after a restart is therefore (N-1)*TICK_DIV+1 .. N*TICK_DIV cycles long.
  - All later phases are exactly N*TICK_DIV cycles.
- Channels are fully independent; a change on one never disturbs another.
- Reset mid-sequence forces the reset values immediately (async). The first edge after release restarts any channel whose inputs differ from {00,0}.

Test Plan:
Params: CHANNELS=2, TICK_DIV=4, BLINK_TICKS=2, ON_TICKS=1, OFF_TICKS=1, GAP_TICKS=3.
- Reset: assert reset with mode=0101 -> led=00, cycle_pulse=00 asynchronously. Release -> led=11 one edge later.
- Prescaler: count ticks over 40 cycles after reset release -> exactly 10 ticks, spaced 4 cycles apart.
- BLINK, ch0 mode=10 applied when prescaler=0:
  - led0=1 next edge;
  - led0 toggles every 8 cycles thereafter;
  - led1 unaffected.
- CODE K=3, ch1 mode=11, code=3:
  - led1 pattern in ticks: 1,0,1,0,1,0,0,0,0, repeating (9-tick = 36-cycle period);
  - cycle_pulse1 high one cycle, coincident with each repeat's first 1, never on initial entry.
- Restart mid-code: change code 3->2 during the second flash -> next edge led1=1, flash count restarts. New pattern is 1,0,1,0,0,0,0. Same-cycle tick is ignored.
- K=0 and OFF: code=0 in mode 11 -> led1 stays 0 and no cycle_pulse for 100 cycles. mode=00 -> led=0. mode=01 -> led=1 one edge later.

Source files
------------

// File: rtl/led_indicator_bank.sv
// Multi-channel LED driver: per-channel OFF / ON / fixed-rate BLINK / repeating flash CODE,
// all paced by one shared free-running prescaler tick.
module led_indicator_bank #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned TICK_DIV    = 120000,
    parameter int unsigned BLINK_TICKS = 50,
    parameter int unsigned ON_TICKS    = 20,
    parameter int unsigned OFF_TICKS   = 30,
    parameter int unsigned GAP_TICKS   = 150
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [2*CHANNELS-1:0]   mode,
    input  logic [4*CHANNELS-1:0]   code,
    output logic [CHANNELS-1:0]     led,
    output logic [CHANNELS-1:0]     cycle_pulse
);

    localparam int unsigned MaxAB = (BLINK_TICKS > ON_TICKS) ? BLINK_TICKS : ON_TICKS;
    localparam int unsigned MaxCD = (OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS;
    localparam int unsigned MaxTicks = (MaxAB > MaxCD) ? MaxAB : MaxCD;
    localparam int unsigned TW = $clog2(MaxTicks) + 1;
    localparam int unsigned PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] BlinkLast = TW'(BLINK_TICKS - 1);
    localparam logic [TW-1:0] OnLast    = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OffLast   = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] GapLast   = TW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {StFlashOn, StFlashOff, StGap} state_e;

    logic [PW-1:0] r_presc;
    logic          w_tick;

    assign w_tick = (r_presc == PrescLast);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [5:0]    w_cfg;
        logic          w_entry_led;
        logic [5:0]    r_cfg;
        state_e        r_state;
        logic [TW-1:0] r_timer;
        logic [3:0]    r_flash;
        logic          r_led;
        logic          r_pulse;

        assign w_cfg = {mode[2*i+:2], code[4*i+:4]};

        always_comb begin
            w_entry_led = 1'b0;
            unique case (w_cfg[5:4])
                2'b00:   w_entry_led = 1'b0;
                2'b01:   w_entry_led = 1'b1;
                2'b10:   w_entry_led = 1'b1;
                default: w_entry_led = (w_cfg[3:0] != 4'd0);
            endcase
        end

        // A config change restarts the channel and swallows any tick on the same edge.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_cfg   <= '0;
                r_state <= StFlashOn;
                r_timer <= '0;
                r_flash <= '0;
                r_led   <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
                if (w_cfg != r_cfg) begin
                    r_cfg   <= w_cfg;
                    r_state <= StFlashOn;
                    r_timer <= '0;
                    r_flash <= '0;
                    r_led   <= w_entry_led;
                end else begin
                    unique case (r_cfg[5:4])
                        2'b00: r_led <= 1'b0;
                        2'b01: r_led <= 1'b1;
                        2'b10: begin
                            if (w_tick) begin
                                if (r_timer == BlinkLast) begin
                                    r_led   <= ~r_led;
                                    r_timer <= '0;
                                end else begin
                                    r_timer <= r_timer + TW'(1);
                                end
                            end
                        end
                        default: begin
                            if (r_cfg[3:0] == 4'd0) begin
                                r_led <= 1'b0;
                            end else if (w_tick) begin
                                unique case (r_state)
                                    StFlashOn: begin
                                        if (r_timer == OnLast) begin
                                            r_state <= StFlashOff;
                                            r_led   <= 1'b0;
                                            r_timer <= '0;
                                        end else begin
                                            r_timer <= r_timer + TW'(1);
                                        end
                                    end
                                    StFlashOff: begin
                                        if (r_timer == OffLast) begin
                                            r_timer <= '0;
                                            if (r_flash == r_cfg[3:0] - 4'd1) begin
                                                r_state <= StGap;
                                            end else begin
                                                r_flash <= r_flash + 4'd1;
                                                r_state <= StFlashOn;
                                                r_led   <= 1'b1;
                                            end
                                        end else begin
                                            r_timer <= r_timer + TW'(1);
                                        end
                                    end
                                    StGap: begin
                                        if (r_timer == GapLast) begin
                                            r_state <= StFlashOn;
                                            r_flash <= '0;
                                            r_led   <= 1'b1;
                                            r_pulse <= 1'b1;
                                            r_timer <= '0;
                                        end else begin
                                            r_timer <= r_timer + TW'(1);
                                        end
                                    end
                                    default: r_state <= StFlashOn;
                                endcase
                            end
                        end
                    endcase
                end
            end
        end

        assign led[i]         = r_led;
        assign cycle_pulse[i] = r_pulse;
    end

endmodule
